// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, grant ids, word width.
package mem_port_arbiter_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_DONE  = 2'd3;

    localparam logic ARB_GNT_IF = 1'b0;
    localparam logic ARB_GNT_D  = 1'b1;

    // The wait timer counts down from latency-1 so that it reads zero in the capture cycle.
    function automatic logic [3:0] timer_load(input int latency);
        return 4'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// mem_wait_timer: 4-bit down-counter with synchronous load, decrement and zero flag.
module mem_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between fetch (IF) and load/store (D) with a fixed-latency FSM.
// Optional macro ARB_PERF_EN adds stall-cycle and request-conflict counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = WORD_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_conflict_cnt
`endif
);

    logic [1:0] state;
    logic       gnt;
    logic       last_grant;
    logic       lat_we;
    logic       timer_zero;
    logic       any_req;
    logic       pick_d;

    assign any_req = if_req | mem_req;
    // D wins a tie unless it was the port served last.
    assign pick_d  = mem_req & (~if_req | (last_grant == ARB_GNT_IF));

    // Reset forces every output low, including the combinational stall.
    assign stall = ~rst & ((if_req & ~if_ready) | (mem_req & ~mem_ready));

    mem_wait_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ARB_ISSUE),
        .load_val (timer_load(MEM_LATENCY)),
        .dec      (state == ARB_WAIT),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            gnt        <= ARB_GNT_IF;
            last_grant <= ARB_GNT_IF;
            lat_we     <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                ARB_IDLE: if (any_req) begin
                    state    <= ARB_ISSUE;
                    gnt      <= pick_d ? ARB_GNT_D : ARB_GNT_IF;
                    lat_we   <= pick_d & mem_we;
                    ram_en   <= 1'b1;
                    ram_we   <= pick_d & mem_we;
                    ram_addr <= pick_d ? mem_addr : if_addr;
                    if (pick_d) ram_wdata <= mem_wdata;
                end
                ARB_ISSUE: state <= ARB_WAIT;
                ARB_WAIT: if (timer_zero) begin
                    // Ready is registered here so it is high for the whole DONE cycle.
                    state <= ARB_DONE;
                    if (gnt == ARB_GNT_D) begin
                        mem_ready <= 1'b1;
                        if (!lat_we) mem_rdata <= ram_rdata;
                    end else begin
                        if_ready <= 1'b1;
                        if_rdata <= ram_rdata;
                    end
                end
                ARB_DONE: begin
                    state      <= ARB_IDLE;
                    last_grant <= gnt;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt    <= 32'd0;
            perf_conflict_cnt <= 32'd0;
        end else begin
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (state == ARB_IDLE && if_req && mem_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a phase-count transaction model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, if_ready, mem_req, mem_we, mem_ready, stall, ram_en, ram_we;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_conflict_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int done6    = 0;

    mem_port_arbiter #(.MEM_LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Environment RAM: read data is valid only in the cycle L after the ram_en cycle.
    logic [31:0] ram     [64];
    logic [31:0] ref_mem [64];
    int          r_cnt = 0;
    logic [31:0] r_data;

    always @(negedge clk) begin
        if (rst) begin
            r_cnt     = 0;
            ram_rdata = $urandom;
        end else begin
            if (r_cnt > 0) begin
                r_cnt--;
                ram_rdata = (r_cnt == 0) ? r_data : $urandom;
            end else begin
                ram_rdata = $urandom;
            end
            if (ram_en) begin
                if (ram_we) ram[ram_addr[7:2]] = ram_wdata;
                r_data = ram[ram_addr[7:2]];
                r_cnt  = L;
            end
        end
    end

    // Model: a grant starts an access; its phase (edges since grant) decides every output.
    bit          m_active, m_gnt_d, m_last_d, m_we, e_ifr, e_memr;
    int          m_age;
    logic [31:0] m_addr, m_ram_addr, m_ram_wdata, e_if_rdata, e_mem_rdata, m_conf, m_stall_cnt;

    task automatic model_reset();
        m_active = 0; m_last_d = 0; m_age = 0; m_gnt_d = 0; m_we = 0;
        e_ifr = 0; e_memr = 0; e_if_rdata = 0; e_mem_rdata = 0;
        m_ram_addr = 0; m_ram_wdata = 0; m_conf = 0; m_stall_cnt = 0;
    endtask

    task automatic step();
        bit st_edge, d;
        st_edge = (if_req && !e_ifr) || (mem_req && !e_memr);
        @(posedge clk);
        if (st_edge) m_stall_cnt++;
        if ((!m_active || m_age >= L + 2) && (if_req || mem_req)) begin
            d = mem_req && (!if_req || !m_last_d);
            if (if_req && mem_req) m_conf++;
            m_active = 1; m_age = 0; m_gnt_d = d; m_last_d = d;
            m_addr = d ? mem_addr : if_addr;
            m_we   = d && mem_we;
            m_ram_addr = m_addr;
            if (d) m_ram_wdata = mem_wdata;
            if (m_we) ref_mem[m_addr[7:2]] = mem_wdata;
        end else if (m_active) begin
            m_age++;
        end
        e_ifr  = m_active && m_age == L + 1 && !m_gnt_d;
        e_memr = m_active && m_age == L + 1 && m_gnt_d;
        if (e_ifr) e_if_rdata = ref_mem[m_addr[7:2]];
        if (e_memr && !m_we) e_mem_rdata = ref_mem[m_addr[7:2]];
        @(negedge clk);
        check("ram_en", ram_en, m_active && m_age == 0);
        check("ram_we", ram_we, m_active && m_age == 0 && m_we);
        check("ram_addr", ram_addr, m_ram_addr);
        if (m_active && m_age == 0 && m_we) check("ram_wdata", ram_wdata, m_ram_wdata);
        check("if_ready", if_ready, e_ifr);
        check("mem_ready", mem_ready, e_memr);
        check("if_rdata", if_rdata, e_if_rdata);
        check("mem_rdata", mem_rdata, e_mem_rdata);
        check("stall", stall, (if_req && !e_ifr) || (mem_req && !e_memr));
`ifdef ARB_PERF_EN
        check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
        check("perf_conflict_cnt", perf_conflict_cnt, m_conf);
`endif
    endtask

    task automatic wait_ready(input bit port_d, output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if ((port_d ? mem_ready : if_ready) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        rst = 1'b1; if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        model_reset();
        #12;
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ready", {if_ready, mem_ready}, 0);
        check("rst_rdata", if_rdata | mem_rdata, 0);
        check("rst_stall", stall, 0);
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single load
        ram[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        mem_req = 1'b1; mem_addr = 32'h40;
        wait_ready(1'b1, n);
        check("load_latency", n, L + 2);
        check("load_data", mem_rdata, 32'hDEADBEEF);

        // Store issued straight after, so one IDLE cycle intervenes
        mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h12345678;
        wait_ready(1'b1, n);
        check("store_spacing", n, L + 3);
        check("store_keeps_rdata", mem_rdata, 32'hDEADBEEF);
        check("store_ram_word", ram[32], 32'h12345678);
        mem_req = 1'b0; mem_we = 1'b0;
        step();

        // Load whose request drops during WAIT, then a fetch
        mem_req = 1'b1; mem_addr = 32'h44;
        step(); step();
        mem_req = 1'b0;
        wait_ready(1'b1, n);
        check("drop_ready", n, L);
        if_req = 1'b1; if_addr = 32'h80;
        wait_ready(1'b0, n);
        check("after_drop_fetch", n, L + 3);
        check("fetch_sees_store", if_rdata, 32'h12345678);
        if_req = 1'b0;
        step();

        // Asynchronous reset in the middle of WAIT
        if_req = 1'b1; if_addr = 32'h40;
        step(); step();
        #1 rst = 1'b1;
        #1;
        check("rstmid_stall", stall, 0);
        check("rstmid_ready", {if_ready, mem_ready}, 0);
        check("rstmid_ram_en", ram_en, 0);
        check("rstmid_rdata", if_rdata | mem_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_ready(1'b0, n);
        check("rstmid_fresh_fetch", n, L + 2);
        check("rstmid_fetch_data", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;

        // Conflict straight after reset: D first, then IF
        apply_reset();
        if_req = 1'b1; if_addr = 32'h80; mem_req = 1'b1; mem_addr = 32'h40;
        wait_ready(1'b1, n);
        check("conflict_d_first", n, L + 2);
        mem_req = 1'b0;
        wait_ready(1'b0, n);
        check("conflict_if_second", n, L + 3);
`ifdef ARB_PERF_EN
        check("conflict_count", perf_conflict_cnt, 1);
`endif
        if_req = 1'b0;

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            step();
            if (e_ifr) if_req = 1'b0;
            if (e_memr) mem_req = 1'b0;
            if (mem_req && $urandom_range(0, 15) == 0) mem_req = 1'b0;
            if (!if_req && !(m_active && !m_gnt_d && m_age <= L + 1) && $urandom_range(0, 2) == 0)
                if_req = 1'b1;
            if (!mem_req && !(m_active && m_gnt_d && m_age <= L + 1) && $urandom_range(0, 2) == 0)
                mem_req = 1'b1;
            if_addr   = $urandom;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_we    = 1'($urandom_range(0, 1));
        end

        for (int i = 0; i < 300 && done6 < 2; i++) @(negedge clk);
        check("latency_sweep_done", done6, 2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Back-to-back fetches at the extreme latencies
    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int LG = (g == 0) ? 1 : 15;
        logic        g_rst, g_req, g_ready, g_mready, g_stall, g_en, g_we;
        logic [31:0] g_addr, g_rdata, g_mrdata, g_raddr, g_rwdata, g_rrdata;
`ifdef ARB_PERF_EN
        logic [31:0] g_pst, g_pcf;
`endif
        int          g_cnt = 0;
        logic [31:0] g_dat;

        mem_port_arbiter #(.MEM_LATENCY(LG)) u_dut (
            .clk(clk), .rst(g_rst),
            .if_req(g_req), .if_addr(g_addr), .if_rdata(g_rdata), .if_ready(g_ready),
            .mem_req(1'b0), .mem_we(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
            .mem_rdata(g_mrdata), .mem_ready(g_mready), .stall(g_stall),
            .ram_en(g_en), .ram_we(g_we), .ram_addr(g_raddr), .ram_wdata(g_rwdata),
            .ram_rdata(g_rrdata)
`ifdef ARB_PERF_EN
            , .perf_stall_cnt(g_pst), .perf_conflict_cnt(g_pcf)
`endif
        );

        always @(negedge clk) begin
            if (g_cnt > 0) begin
                g_cnt--;
                g_rrdata = (g_cnt == 0) ? g_dat : $urandom;
            end else begin
                g_rrdata = $urandom;
            end
            if (g_en) begin
                g_dat = g_raddr ^ 32'hA5A50000;
                g_cnt = LG;
            end
        end

        initial begin
            int last, pulses;
            g_rst = 1'b1; g_req = 1'b0; g_addr = 32'h100 * (g + 1);
            last = -1; pulses = 0;
            repeat (2) @(negedge clk);
            g_rst = 1'b0; g_req = 1'b1;
            for (int c = 1; c <= 6 * (LG + 3) + 2; c++) begin
                @(negedge clk);
                if (g_ready) begin
                    if (last < 0) check($sformatf("lat%0d_first", LG), c, LG + 2);
                    else check($sformatf("lat%0d_spacing", LG), c - last, LG + 3);
                    check($sformatf("lat%0d_data", LG), g_rdata, g_addr ^ 32'hA5A50000);
                    last = c;
                    pulses++;
                    g_addr = g_addr + 32'd4;
                end
            end
            check($sformatf("lat%0d_pulses", LG), pulses, 6);
            done6++;
        end
    end

endmodule
